// File: rtl/rtc_edit_bank.sv
// rtc_edit_bank: nine-byte packed-BCD bank for the clock display with load port, push-button editing and commit stream.
// Optional macro RTC_EDIT_DEC_EN enables the decrement button; without it btn_dec is ignored.
module rtc_edit_bank (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    input  logic       ld_valid,
    input  logic [3:0] ld_addr,
    input  logic [7:0] ld_data,
    output logic       ld_ready,
    input  logic [1:0] edit_mode,
    input  logic [1:0] edit_pos,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output logic       wr_valid,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic       wr_ready,
    output logic       busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_EDIT, ST_FLUSH} state_t;

    state_t     state_q, state_d;
    logic [1:0] cur_grp_q, cur_grp_d;
    logic [1:0] beat_q, beat_d;
    logic [7:0] bank_q [9];
    logic [7:0] bank_d [9];
    logic       inc_prev_q, inc_edge_q;
    logic       step_inc;
    logic [3:0] sel_addr;
    logic [3:0] flush_addr;

    // Group number of a bank position: time=3, date=2, timer=1, 0 for no position.
    function automatic logic [1:0] grp_of(input logic [3:0] a);
        if (a <= 4'd2)      return 2'd3;
        else if (a <= 4'd5) return 2'd2;
        else if (a <= 4'd8) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [3:0] base_of(input logic [1:0] g);
        case (g)
            2'd3:    return 4'd0;
            2'd2:    return 4'd3;
            default: return 4'd6;
        endcase
    endfunction

    function automatic logic [7:0] field_min(input logic [3:0] a);
        return (a == 4'd4 || a == 4'd5) ? 8'h01 : 8'h00;
    endfunction

    function automatic logic [7:0] field_max(input logic [3:0] a);
        case (a)
            4'd2, 4'd8: return 8'h23;
            4'd3:       return 8'h99;
            4'd4:       return 8'h12;
            4'd5:       return 8'h31;
            default:    return 8'h59;
        endcase
    endfunction

    function automatic logic field_ok(input logic [3:0] a, input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) &&
               (v >= field_min(a)) && (v <= field_max(a));
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [3:0] a, input logic [7:0] v);
        if (!field_ok(a, v) || v == field_max(a)) return field_min(a);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

`ifdef RTC_EDIT_DEC_EN
    logic dec_prev_q, dec_edge_q;
    logic step_dec;

    function automatic logic [7:0] bcd_dec(input logic [3:0] a, input logic [7:0] v);
        if (!field_ok(a, v)) return field_min(a);
        if (v == field_min(a)) return field_max(a);
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            dec_prev_q <= 1'b0;
            dec_edge_q <= 1'b0;
        end else begin
            dec_prev_q <= btn_dec;
            dec_edge_q <= btn_dec & ~dec_prev_q;
        end
    end

    // Simultaneous edges cancel.
    assign step_inc = inc_edge_q & ~dec_edge_q;
    assign step_dec = dec_edge_q & ~inc_edge_q;
`else
    logic unused_btn_dec;

    assign unused_btn_dec = btn_dec;
    assign step_inc       = inc_edge_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            inc_prev_q <= 1'b0;
            inc_edge_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            inc_prev_q <= btn_inc;
            inc_edge_q <= btn_inc & ~inc_prev_q;
        end
    end

    assign sel_addr   = base_of(cur_grp_q) + 4'd3 - {2'b00, edit_pos};
    assign flush_addr = base_of(cur_grp_q) + 4'd2 - {2'b00, beat_q};

    always_comb begin
        // NOTE: every output and _d gets a default first so no path infers a latch.
        state_d   = state_q;
        cur_grp_d = cur_grp_q;
        beat_d    = beat_q;
        bank_d    = bank_q;
        ld_ready  = 1'b1;
        wr_valid  = 1'b0;
        wr_addr   = 4'd0;
        wr_data   = 8'h00;

        case (state_q)
            ST_IDLE: begin
                if (edit_mode != 2'd0) begin
                    state_d   = ST_EDIT;
                    cur_grp_d = edit_mode;
                end
            end
            ST_EDIT: begin
                ld_ready = (grp_of(ld_addr) != cur_grp_q);
                if (edit_pos != 2'd0) begin
                    if (step_inc) bank_d[sel_addr] = bcd_inc(sel_addr, bank_q[sel_addr]);
`ifdef RTC_EDIT_DEC_EN
                    else if (step_dec) bank_d[sel_addr] = bcd_dec(sel_addr, bank_q[sel_addr]);
`endif
                end
                if (edit_mode != cur_grp_q) begin
                    state_d = ST_FLUSH;
                    beat_d  = 2'd0;
                end
            end
            ST_FLUSH: begin
                ld_ready = (grp_of(ld_addr) != cur_grp_q);
                wr_valid = 1'b1;
                wr_addr  = flush_addr;
                wr_data  = bank_q[flush_addr];
                if (wr_ready) begin
                    if (beat_q == 2'd2) begin
                        beat_d = 2'd0;
                        if (edit_mode != 2'd0) begin
                            state_d   = ST_EDIT;
                            cur_grp_d = edit_mode;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Loads never collide with edits: ld_ready is low for the group being edited.
        if (ld_valid && ld_ready && ld_addr <= 4'd8) bank_d[ld_addr] = ld_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cur_grp_q <= 2'd0;
            beat_q    <= 2'd0;
            // NOTE: the bank is a handful of flops with defined power-on contents, so it is reset like any register.
            for (int i = 0; i < 9; i++) bank_q[i] <= (i == 4 || i == 5) ? 8'h01 : 8'h00;
        end else begin
            state_q   <= state_d;
            cur_grp_q <= cur_grp_d;
            beat_q    <= beat_d;
            bank_q    <= bank_d;
        end
    end

    assign rd_data = (rd_addr <= 4'd8) ? bank_q[rd_addr] : 8'h00;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rtc_edit_bank.sv
// Directed bench for rtc_edit_bank: reset contents, loads, BCD edit wrap, commit stream with backpressure, reset mid-flush.
module tb_rtc_edit_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       ld_valid;
    logic [3:0] ld_addr;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic [1:0] edit_mode;
    logic [1:0] edit_pos;
    logic       btn_inc;
    logic       btn_dec;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       busy;

    int total = 0;
    int bad   = 0;

`ifdef RTC_EDIT_DEC_EN
    localparam logic [7:0] DAY_FINAL   = 8'h31;
    localparam logic [7:0] MONTH_FINAL = 8'h12;
`else
    localparam logic [7:0] DAY_FINAL   = 8'h02;
    localparam logic [7:0] MONTH_FINAL = 8'h01;
`endif

    rtc_edit_bank dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .edit_mode (edit_mode),
        .edit_pos  (edit_pos),
        .btn_inc   (btn_inc),
        .btn_dec   (btn_dec),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] a, input logic [7:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        step();
        ld_valid = 1'b0;
    endtask

    task automatic press_inc();
        btn_inc = 1'b1;
        step();
        step();
        btn_inc = 1'b0;
        step();
    endtask

    task automatic test_reset();
        logic [7:0] exp_rd [10];
        exp_rd = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || ld_ready !== 1'b1 || wr_valid !== 1'b0 || wr_addr !== 4'd0 || wr_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b ld_ready=%b wr_valid=%b wr_addr=%0d wr_data=%h want 0 1 0 0 00",
                     busy, ld_ready, wr_valid, wr_addr, wr_data);
        end
        for (int i = 0; i < 10; i++) begin
            rd_addr = 4'(i);
            #1;
            total++;
            if (rd_data !== exp_rd[i]) begin
                bad++;
                $display("FAIL reset_rd[%0d]: got %h want %h", i, rd_data, exp_rd[i]);
            end
        end
        ld_valid = 1'b1;
        ld_addr  = 4'd9;
        ld_data  = 8'h55;
        #1;
        total++;
        if (ld_ready !== 1'b1) begin
            bad++;
            $display("FAIL load_addr9_ready: got %b want 1", ld_ready);
        end
        step();
        ld_valid = 1'b0;
        rd_addr  = 4'd9;
        #1;
        total++;
        if (rd_data !== 8'h00) begin
            bad++;
            $display("FAIL load_addr9_dropped: got %h want 00", rd_data);
        end
        rd_addr = 4'd15;
        #1;
        total++;
        if (rd_data !== 8'h00) begin
            bad++;
            $display("FAIL rd_addr15: got %h want 00", rd_data);
        end
    endtask

    task automatic test_time_edit();
        logic [3:0] ea [3];
        logic [7:0] ed [3];
        ea = '{4'd2, 4'd1, 4'd0};
        ed = '{8'h00, 8'h10, 8'h00};
        do_load(4'd2, 8'h23);
        rd_addr = 4'd2;
        #1;
        total++;
        if (rd_data !== 8'h23) begin
            bad++;
            $display("FAIL load_visible: got %h want 23", rd_data);
        end
        do_load(4'd1, 8'h09);
        do_load(4'd0, 8'h4A);
        edit_mode = 2'd3;
        edit_pos  = 2'd1;
        step();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_on_edit: got %b want 1", busy);
        end
        // Load into the group being edited is refused; other groups still load.
        ld_valid = 1'b1;
        ld_addr  = 4'd1;
        ld_data  = 8'h33;
        #1;
        total++;
        if (ld_ready !== 1'b0) begin
            bad++;
            $display("FAIL ld_blocked_ready: got %b want 0", ld_ready);
        end
        step();
        ld_valid = 1'b0;
        rd_addr  = 4'd1;
        #1;
        total++;
        if (rd_data !== 8'h09) begin
            bad++;
            $display("FAIL ld_blocked_bank: got %h want 09", rd_data);
        end
        ld_valid = 1'b1;
        ld_addr  = 4'd4;
        ld_data  = 8'h07;
        #1;
        total++;
        if (ld_ready !== 1'b1) begin
            bad++;
            $display("FAIL ld_other_ready: got %b want 1", ld_ready);
        end
        step();
        ld_valid = 1'b0;
        rd_addr  = 4'd4;
        #1;
        total++;
        if (rd_data !== 8'h07) begin
            bad++;
            $display("FAIL ld_other_bank: got %h want 07", rd_data);
        end
        btn_inc = 1'b1;
        rd_addr = 4'd2;
        step();
        total++;
        if (rd_data !== 8'h23) begin
            bad++;
            $display("FAIL hours_inc_early: got %h want 23", rd_data);
        end
        step();
        total++;
        if (rd_data !== 8'h00) begin
            bad++;
            $display("FAIL hours_wrap: got %h want 00", rd_data);
        end
        btn_inc = 1'b0;
        step();
        edit_pos = 2'd2;
        press_inc();
        rd_addr = 4'd1;
        #1;
        total++;
        if (rd_data !== 8'h10) begin
            bad++;
            $display("FAIL minutes_carry: got %h want 10", rd_data);
        end
        edit_pos = 2'd3;
        press_inc();
        rd_addr = 4'd0;
        #1;
        total++;
        if (rd_data !== 8'h00) begin
            bad++;
            $display("FAIL seconds_nonbcd: got %h want 00", rd_data);
        end
        edit_mode = 2'd0;
        wr_ready  = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (wr_valid !== 1'b1 || wr_addr !== ea[k] || wr_data !== ed[k]) begin
                bad++;
                $display("FAIL time_flush beat%0d: got v=%b a=%0d d=%h want v=1 a=%0d d=%h",
                         k, wr_valid, wr_addr, wr_data, ea[k], ed[k]);
            end
            step();
        end
        total++;
        if (busy !== 1'b0 || wr_valid !== 1'b0) begin
            bad++;
            $display("FAIL time_flush_done: got busy=%b wr_valid=%b want 0 0", busy, wr_valid);
        end
    endtask

    task automatic test_date_edit();
        logic [3:0] ea [3];
        logic [7:0] ed [3];
        ea = '{4'd5, 4'd4, 4'd3};
        ed = '{DAY_FINAL, MONTH_FINAL, 8'h01};
        do_load(4'd4, 8'h12);
        edit_mode = 2'd2;
        edit_pos  = 2'd2;
        step();
        press_inc();
        rd_addr = 4'd4;
        #1;
        total++;
        if (rd_data !== 8'h01) begin
            bad++;
            $display("FAIL month_wrap_inc: got %h want 01", rd_data);
        end
`ifdef RTC_EDIT_DEC_EN
        btn_dec = 1'b1;
        step();
        step();
        btn_dec = 1'b0;
        step();
        total++;
        if (rd_data !== 8'h12) begin
            bad++;
            $display("FAIL month_wrap_dec: got %h want 12", rd_data);
        end
`endif
        // Both buttons together: cancel with decrement enabled, plain increment otherwise.
        edit_pos = 2'd1;
        btn_inc  = 1'b1;
        btn_dec  = 1'b1;
        step();
        step();
        btn_inc  = 1'b0;
        btn_dec  = 1'b0;
        step();
        rd_addr  = 4'd5;
        #1;
        total++;
`ifdef RTC_EDIT_DEC_EN
        if (rd_data !== 8'h01) begin
            bad++;
            $display("FAIL day_both_buttons: got %h want 01", rd_data);
        end
        btn_dec = 1'b1;
        step();
        step();
        btn_dec = 1'b0;
        step();
        total++;
        if (rd_data !== 8'h31) begin
            bad++;
            $display("FAIL day_wrap_dec: got %h want 31", rd_data);
        end
`else
        if (rd_data !== 8'h02) begin
            bad++;
            $display("FAIL day_dec_ignored: got %h want 02", rd_data);
        end
`endif
        edit_pos = 2'd3;
        press_inc();
        rd_addr = 4'd3;
        #1;
        total++;
        if (rd_data !== 8'h01) begin
            bad++;
            $display("FAIL year_inc: got %h want 01", rd_data);
        end
        edit_mode = 2'd0;
        wr_ready  = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (wr_valid !== 1'b1 || wr_addr !== ea[k] || wr_data !== ed[k]) begin
                bad++;
                $display("FAIL date_flush beat%0d: got v=%b a=%0d d=%h want v=1 a=%0d d=%h",
                         k, wr_valid, wr_addr, wr_data, ea[k], ed[k]);
            end
            step();
        end
    endtask

    task automatic test_timer_backpressure();
        logic [3:0] ea [3];
        logic [7:0] ed [3];
        ea = '{4'd8, 4'd7, 4'd6};
        ed = '{8'h12, 8'h00, 8'h30};
        do_load(4'd8, 8'h12);
        do_load(4'd7, 8'h59);
        do_load(4'd6, 8'h30);
        edit_mode = 2'd1;
        edit_pos  = 2'd2;
        step();
        press_inc();
        rd_addr = 4'd7;
        #1;
        total++;
        if (rd_data !== 8'h00) begin
            bad++;
            $display("FAIL timer_min_wrap: got %h want 00", rd_data);
        end
        edit_mode = 2'd0;
        wr_ready  = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (wr_valid !== 1'b1 || wr_addr !== 4'd8 || wr_data !== 8'h12) begin
                bad++;
                $display("FAIL timer_hold cyc%0d: got v=%b a=%0d d=%h want v=1 a=8 d=12",
                         k, wr_valid, wr_addr, wr_data);
            end
            step();
        end
        wr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (wr_valid !== 1'b1 || wr_addr !== ea[k] || wr_data !== ed[k] || busy !== 1'b1) begin
                bad++;
                $display("FAIL timer_flush beat%0d: got v=%b a=%0d d=%h busy=%b want v=1 a=%0d d=%h busy=1",
                         k, wr_valid, wr_addr, wr_data, busy, ea[k], ed[k]);
            end
            step();
        end
        total++;
        if (busy !== 1'b0 || wr_valid !== 1'b0) begin
            bad++;
            $display("FAIL timer_busy_fall: got busy=%b wr_valid=%b want 0 0", busy, wr_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ea [3];
        logic [7:0] ed [3];
        logic [7:0] exp_rd [10];
        ea = '{4'd2, 4'd1, 4'd0};
        ed = '{8'h00, 8'h10, 8'h00};
        exp_rd = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        edit_mode = 2'd3;
        edit_pos  = 2'd0;
        wr_ready  = 1'b1;
        step();
        edit_mode = 2'd2;
        step();
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (wr_valid !== 1'b1 || wr_addr !== ea[k] || wr_data !== ed[k]) begin
                bad++;
                $display("FAIL b2b_flush beat%0d: got v=%b a=%0d d=%h want v=1 a=%0d d=%h",
                         k, wr_valid, wr_addr, wr_data, ea[k], ed[k]);
            end
            step();
        end
        ld_addr = 4'd4;
        #1;
        total++;
        if (busy !== 1'b1 || wr_valid !== 1'b0 || ld_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_relatch: got busy=%b wr_valid=%b ld_ready(addr4)=%b want 1 0 0",
                     busy, wr_valid, ld_ready);
        end
        ld_addr = 4'd1;
        #1;
        total++;
        if (ld_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_time_ready: got %b want 1", ld_ready);
        end
        edit_mode = 2'd1;
        step();
        total++;
        if (wr_valid !== 1'b1 || wr_addr !== 4'd5 || wr_data !== DAY_FINAL) begin
            bad++;
            $display("FAIL rstflush_beat0: got v=%b a=%0d d=%h want v=1 a=5 d=%h", wr_valid, wr_addr, wr_data, DAY_FINAL);
        end
        step();
        total++;
        if (wr_valid !== 1'b1 || wr_addr !== 4'd4 || wr_data !== MONTH_FINAL) begin
            bad++;
            $display("FAIL rstflush_beat1: got v=%b a=%0d d=%h want v=1 a=4 d=%h", wr_valid, wr_addr, wr_data, MONTH_FINAL);
        end
        reset     = 1'b1;
        edit_mode = 2'd0;
        step();
        reset = 1'b0;
        total++;
        if (wr_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rstflush_abandon: got wr_valid=%b busy=%b want 0 0", wr_valid, busy);
        end
        for (int i = 0; i < 10; i++) begin
            rd_addr = 4'(i);
            #1;
            total++;
            if (rd_data !== exp_rd[i]) begin
                bad++;
                $display("FAIL rstflush_rd[%0d]: got %h want %h", i, rd_data, exp_rd[i]);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        rd_addr   = 4'd0;
        ld_valid  = 1'b0;
        ld_addr   = 4'd0;
        ld_data   = 8'h00;
        edit_mode = 2'd0;
        edit_pos  = 2'd0;
        btn_inc   = 1'b0;
        btn_dec   = 1'b0;
        wr_ready  = 1'b0;
        test_reset();
        test_time_edit();
        test_date_edit();
        test_timer_backpressure();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
